// File: rtl/cpu_configuration.sv
// Shared CPU configuration: datapath width, register addressing and
// the issue FSM state encoding.
package cpu_configuration;
    localparam int CFG_XLEN = 32;
    localparam int REG_AW = 5;
    localparam int NREGS = 1 << REG_AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        HAZARD = 2'd2
    } issue_state_e;
endpackage

// File: rtl/issue_unit_if.sv
// Operand lookup bundle between the issue control and the bypass block:
// master presents sources, writeback and the new pending mark.
interface issue_unit_if #(
    parameter int XLEN = cpu_configuration::CFG_XLEN
);
    import cpu_configuration::*;

    logic [REG_AW-1:0] rs1_ad;
    logic [REG_AW-1:0] rs2_ad;
    logic              rs1_live;
    logic              rs2_live;
    logic [XLEN-1:0]   r0_data;
    logic [XLEN-1:0]   r1_data;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_ad;
    logic [XLEN-1:0]   wb_data;
    logic              set_en;
    logic [REG_AW-1:0] set_ad;
    logic              haz1;
    logic              haz2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;

    modport master (
        output rs1_ad, rs2_ad, rs1_live, rs2_live,
        output r0_data, r1_data,
        output wb_valid, wb_ad, wb_data,
        output set_en, set_ad,
        input  haz1, haz2, rs1_data, rs2_data
    );

    modport slave (
        input  rs1_ad, rs2_ad, rs1_live, rs2_live,
        input  r0_data, r1_data,
        input  wb_valid, wb_ad, wb_data,
        input  set_en, set_ad,
        output haz1, haz2, rs1_data, rs2_data
    );
endinterface

// File: rtl/issue_unit_bypass.sv
// Shadow pending mask and same-cycle writeback forwarding
// (issue_bypass, instantiated only when BYPASS_EN is defined).
module issue_bypass
    import cpu_configuration::*;
(
    input logic         clk,
    input logic         rst_n,
    issue_unit_if.slave bp
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic             fwd1;
    logic             fwd2;

    always_comb begin
        fwd1 = bp.wb_valid && (bp.wb_ad == bp.rs1_ad);
        fwd2 = bp.wb_valid && (bp.wb_ad == bp.rs2_ad);
        // a live source is never x0, so a match implies a real register
        bp.haz1 = bp.rs1_live && pend_q[bp.rs1_ad] && !fwd1;
        bp.haz2 = bp.rs2_live && pend_q[bp.rs2_ad] && !fwd2;
        bp.rs1_data = '0;
        bp.rs2_data = '0;
        if (bp.rs1_live) begin
            bp.rs1_data = fwd1 ? bp.wb_data : bp.r0_data;
        end
        if (bp.rs2_live) begin
            bp.rs2_data = fwd2 ? bp.wb_data : bp.r1_data;
        end
        pend_d = pend_q;
        if (bp.wb_valid) begin
            pend_d[bp.wb_ad] = 1'b0;
        end
        // a new writer issued this cycle outranks an older writeback
        if (bp.set_en) begin
            pend_d[bp.set_ad] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/issue_unit.sv
// Single-issue stage between decode and execute with RAW stall detection.
// Define BYPASS_EN for a local pending mask with writeback forwarding.
module issue_unit
    import cpu_configuration::*;
#(
    parameter int XLEN = CFG_XLEN,
    parameter int OPW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_rs1_use,
    input  logic              dec_rs2_use,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_rd_we,
    input  logic [OPW-1:0]    dec_op,
    input  logic [XLEN-1:0]   dec_imm,
    input  logic [XLEN-1:0]   dec_pc,
    output logic              dec_ready,
    output logic              r0_valid,
    output logic [REG_AW-1:0] r0_ad,
    output logic              r1_valid,
    output logic [REG_AW-1:0] r1_ad,
    output logic              block_rd,
    output logic [REG_AW-1:0] rd,
    input  logic [XLEN-1:0]   r0_data,
    input  logic [XLEN-1:0]   r1_data,
    input  logic              r_v,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_ad,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [OPW-1:0]    ex_op,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_rd_we,
    output logic [15:0]       stall_cycles,
    input  logic              ex_ready
);

    issue_state_e      state_q, state_d;
    logic              ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              we_q, we_d;
    logic [15:0]       stall_q, stall_d;

    logic              rs1_live;
    logic              rs2_live;
    logic              hazard;
    logic              accept;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;

    assign r0_valid = dec_valid & dec_rs1_use;
    assign r0_ad    = dec_rs1;
    assign r1_valid = dec_valid & dec_rs2_use;
    assign r1_ad    = dec_rs2;

    // x0 reads as zero and can never be pending
    assign rs1_live = dec_rs1_use && (dec_rs1 != '0);
    assign rs2_live = dec_rs2_use && (dec_rs2 != '0);

`ifdef BYPASS_EN
    issue_unit_if #(.XLEN(XLEN)) bp ();

    assign bp.rs1_ad   = dec_rs1;
    assign bp.rs2_ad   = dec_rs2;
    assign bp.rs1_live = rs1_live;
    assign bp.rs2_live = rs2_live;
    assign bp.r0_data  = r0_data;
    assign bp.r1_data  = r1_data;
    assign bp.wb_valid = wb_valid;
    assign bp.wb_ad    = wb_ad;
    assign bp.wb_data  = wb_data;
    assign bp.set_en   = block_rd;
    assign bp.set_ad   = dec_rd;

    issue_bypass u_bypass (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    assign hazard = dec_valid & (bp.haz1 | bp.haz2);
    assign src1   = bp.rs1_data;
    assign src2   = bp.rs2_data;

    logic unused_rv;
    assign unused_rv = r_v;
`else
    assign hazard = dec_valid & ~r_v & (rs1_live | rs2_live);
    assign src1   = rs1_live ? r0_data : '0;
    assign src2   = rs2_live ? r1_data : '0;

    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_ad, wb_data};
`endif

    assign dec_ready = ~hazard & ~flush & (~ex_valid_q | ex_ready);
    assign accept    = dec_valid & dec_ready;
    assign block_rd  = accept & dec_rd_we & (dec_rd != '0);
    assign rd        = block_rd ? dec_rd : '0;

    always_comb begin
        ex_valid_d = ex_valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        op_d       = op_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        we_d       = we_q;
        if (accept) begin
            ex_valid_d = 1'b1;
            rs1_d      = src1;
            rs2_d      = src2;
            op_d       = dec_op;
            imm_d      = dec_imm;
            pc_d       = dec_pc;
            rd_d       = dec_rd;
            we_d       = dec_rd_we;
        end else if (ex_ready || flush) begin
            ex_valid_d = 1'b0;
        end

        if (flush) begin
            state_d = IDLE;
        end else if (hazard) begin
            state_d = HAZARD;
        end else if (ex_valid_d) begin
            state_d = BUSY;
        end else begin
            state_d = IDLE;
        end

        stall_d = stall_q;
        if ((state_q == HAZARD) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ex_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            op_q       <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_rs1_data  = rs1_q;
    assign ex_rs2_data  = rs2_q;
    assign ex_op        = op_q;
    assign ex_imm       = imm_q;
    assign ex_pc        = pc_q;
    assign ex_rd        = rd_q;
    assign ex_rd_we     = we_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_issue_unit;
    import cpu_configuration::*;

    localparam int XLEN = 32;
    localparam int OPW  = 8;
`ifdef BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dec_valid, dec_rs1_use, dec_rs2_use, dec_rd_we;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic [OPW-1:0]  dec_op;
    logic [XLEN-1:0] dec_imm, dec_pc;
    logic            dec_ready;
    logic            r0_valid, r1_valid, block_rd;
    logic [4:0]      r0_ad, r1_ad, rd;
    logic [XLEN-1:0] r0_data, r1_data;
    logic            r_v, wb_valid, flush;
    logic [4:0]      wb_ad;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid, ex_rd_we, ex_ready;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [OPW-1:0]  ex_op;
    logic [4:0]      ex_rd;
    logic [15:0]     stall_cycles;

    issue_unit #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_use(dec_rs1_use), .dec_rs2_use(dec_rs2_use),
        .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_op(dec_op),
        .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_ready(dec_ready),
        .r0_valid(r0_valid), .r0_ad(r0_ad), .r1_valid(r1_valid),
        .r1_ad(r1_ad), .block_rd(block_rd), .rd(rd),
        .r0_data(r0_data), .r1_data(r1_data), .r_v(r_v),
        .wb_valid(wb_valid), .wb_ad(wb_ad), .wb_data(wb_data),
        .flush(flush), .ex_valid(ex_valid), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_op(ex_op), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .stall_cycles(stall_cycles), .ex_ready(ex_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: what the execute stage should be holding
    logic            m_exv;
    logic [XLEN-1:0] m_s1, m_s2, m_imm, m_pc;
    logic [OPW-1:0]  m_op;
    logic [4:0]      m_rd;
    logic            m_we;
    int              m_stall;
    bit              m_inhaz;
    bit              m_pend [32];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_exv = 0; m_s1 = 0; m_s2 = 0; m_imm = 0; m_pc = 0;
        m_op = 0; m_rd = 0; m_we = 0; m_stall = 0; m_inhaz = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    task automatic set_idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_use = 0;
        dec_rs2_use = 0; dec_rd = 0; dec_rd_we = 0; dec_op = 0;
        dec_imm = 0; dec_pc = 0; r0_data = 0; r1_data = 0; r_v = 1;
        wb_valid = 0; wb_ad = 0; wb_data = 0; flush = 0; ex_ready = 1;
    endtask

    task automatic set_instr(input logic [4:0] s1, input logic u1,
                             input logic [4:0] s2, input logic u2,
                             input logic [4:0] d, input logic we,
                             input logic [XLEN-1:0] pc);
        dec_valid = 1; dec_rs1 = s1; dec_rs1_use = u1; dec_rs2 = s2;
        dec_rs2_use = u2; dec_rd = d; dec_rd_we = we; dec_pc = pc;
        dec_op = pc[7:0] ^ 8'h5A; dec_imm = ~pc;
        r0_data = pc + 32'h100; r1_data = pc + 32'h200;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1;
    endtask

    task automatic check_ex();
        chk("ex_valid", ex_valid, m_exv);
        chk("stall_cycles", stall_cycles, m_stall[15:0]);
        if (m_exv) begin
            chk("ex_rs1_data", ex_rs1_data, m_s1);
            chk("ex_rs2_data", ex_rs2_data, m_s2);
            chk("ex_op", ex_op, m_op);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rd", ex_rd, m_rd);
            chk("ex_rd_we", ex_rd_we, m_we);
        end
    endtask

    // one clock: check decode-side outputs, advance model, check ex side
    task automatic step(input bit do_chk);
        bit l1, l2, f1, f2, haz, rdy, acc, blk;
        l1 = dec_rs1_use && dec_rs1 != 0;
        l2 = dec_rs2_use && dec_rs2 != 0;
        f1 = BYP && wb_valid && wb_ad == dec_rs1;
        f2 = BYP && wb_valid && wb_ad == dec_rs2;
        if (BYP)
            haz = dec_valid && ((l1 && m_pend[dec_rs1] && !f1) ||
                                (l2 && m_pend[dec_rs2] && !f2));
        else
            haz = dec_valid && !r_v && (l1 || l2);
        rdy = !haz && !flush && (!m_exv || ex_ready);
        acc = dec_valid && rdy;
        blk = acc && dec_rd_we && dec_rd != 0;
        #1;
        if (do_chk) begin
            chk("dec_ready", dec_ready, rdy);
            chk("block_rd", block_rd, blk);
            chk("rd", rd, blk ? dec_rd : 5'd0);
            chk("r0_valid", r0_valid, dec_valid && dec_rs1_use);
            chk("r1_valid", r1_valid, dec_valid && dec_rs2_use);
            chk("r0_ad", r0_ad, dec_rs1);
            chk("r1_ad", r1_ad, dec_rs2);
        end
        if (m_inhaz && m_stall < 65535) m_stall++;
        m_inhaz = haz && !flush;
        if (acc) begin
            m_exv = 1;
            m_s1 = !l1 ? 0 : (f1 ? wb_data : r0_data);
            m_s2 = !l2 ? 0 : (f2 ? wb_data : r1_data);
            m_op = dec_op; m_imm = dec_imm; m_pc = dec_pc;
            m_rd = dec_rd; m_we = dec_rd_we;
        end else if (ex_ready || flush) begin
            m_exv = 0;
        end
        if (BYP) begin
            if (wb_valid) m_pend[wb_ad] = 0;
            if (blk) m_pend[dec_rd] = 1;
        end
        @(posedge clk); #1;
        if (do_chk) check_ex();
    endtask

    typedef struct {
        logic v; logic [4:0] s1; logic u1; logic [4:0] s2; logic u2;
        logic [4:0] d; logic we; logic rv; logic fl; logic [31:0] d0;
        logic e_rdy; logic e_blk; logic [4:0] e_rd; logic e_exv;
        logic [31:0] e_s1;
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{1, 1, 1, 2, 1, 3, 1, 1, 0, 32'h11111111,
                  1, 1, 3, 1, 32'h11111111};
        vt[1] = '{1, 4, 1, 0, 0, 0, 1, 1, 0, 32'h22,
                  1, 0, 0, 1, 32'h22};
        vt[2] = '{1, 4, 1, 0, 0, 7, 0, 1, 0, 32'h33,
                  1, 0, 0, 1, 32'h33};
        vt[3] = '{1, 6, 1, 0, 0, 8, 0, 0, 0, 32'h44,
                  BYP, 0, 0, BYP, 32'h44};
        vt[4] = '{1, 0, 1, 0, 1, 9, 1, 0, 0, 32'hDEAD,
                  1, 1, 9, 1, 32'h0};
        vt[5] = '{0, 1, 1, 0, 0, 9, 1, 1, 0, 32'h55,
                  1, 0, 0, 0, 32'h0};
        vt[6] = '{1, 1, 1, 0, 0, 10, 1, 1, 1, 32'h66,
                  0, 0, 0, 0, 32'h0};

        set_idle();
        #12;
        chk("reset ex_valid async", ex_valid, 0);
        @(posedge clk); #1;
        model_reset();
        chk("reset ex_rs1_data", ex_rs1_data, 0);
        chk("reset ex_pc", ex_pc, 0);
        chk("reset ex_op", ex_op, 0);
        chk("reset ex_rd", ex_rd, 0);
        chk("reset stall", stall_cycles, 0);
        chk("reset state", dut.state_q, IDLE);
        rst_n = 1;

        // vector table
        for (int i = 0; i < 7; i++) begin
            set_idle();
            set_instr(vt[i].s1, vt[i].u1, vt[i].s2, vt[i].u2, vt[i].d,
                      vt[i].we, 32'h1000 + 32'(i) * 4);
            dec_valid = vt[i].v; r_v = vt[i].rv; flush = vt[i].fl;
            r0_data = vt[i].d0;
            #1;
            chk($sformatf("vec%0d dec_ready", i), dec_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d block_rd", i), block_rd, vt[i].e_blk);
            chk($sformatf("vec%0d rd", i), rd, vt[i].e_rd);
            step(1);
            chk($sformatf("vec%0d ex_valid", i), ex_valid, vt[i].e_exv);
            if (vt[i].e_exv)
                chk($sformatf("vec%0d ex_rs1", i), ex_rs1_data, vt[i].e_s1);
        end

        // RAW stall on x3 for four cycles, then release
        do_reset();
        if (BYP) begin
            set_instr(1, 1, 2, 1, 3, 1, 32'h2000);
            step(1);
        end
        set_idle();
        set_instr(3, 1, 0, 0, 4, 1, 32'h2004);
        r_v = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("raw dec_ready", dec_ready, 0);
            step(1);
        end
        chk("raw state", dut.state_q, HAZARD);
        r_v = 1;
        if (BYP) begin
            wb_valid = 1; wb_ad = 3; wb_data = 32'hCAFE0003;
        end
        #1;
        chk("raw release ready", dec_ready, 1);
        step(1);
        chk("raw issued", ex_valid, 1);
        chk("raw stall_cycles", stall_cycles, 16'd4);
        chk("raw ex_pc", ex_pc, 32'h2004);

        // execute back-pressure holds the issued instruction
        do_reset();
        set_instr(1, 1, 2, 1, 6, 1, 32'h3000);
        step(1);
        set_instr(2, 1, 0, 0, 7, 1, 32'h3004);
        ex_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp dec_ready", dec_ready, 0);
            chk("bp block_rd", block_rd, 0);
            step(1);
            chk("bp ex_pc held", ex_pc, 32'h3000);
            chk("bp ex_rd held", ex_rd, 6);
        end
        ex_ready = 1;
        step(1);
        chk("bp next pc", ex_pc, 32'h3004);

        // flush while busy with a valid decode
        flush = 1;
        set_instr(1, 1, 0, 0, 8, 1, 32'h3008);
        #1;
        chk("flush block_rd", block_rd, 0);
        step(1);
        chk("flush ex_valid", ex_valid, 0);
        chk("flush state", dut.state_q, IDLE);
        flush = 0;

`ifdef BYPASS_EN
        do_reset();
        set_instr(1, 1, 0, 0, 5, 1, 32'h4000);
        step(1);
        set_instr(5, 1, 0, 0, 6, 0, 32'h4004);
        wb_valid = 1; wb_ad = 5; wb_data = 32'hDEADBEEF;
        #1;
        chk("fwd dec_ready", dec_ready, 1);
        step(1);
        chk("fwd ex_rs1_data", ex_rs1_data, 32'hDEADBEEF);
`endif

        // mid-operation asynchronous reset
        do_reset();
        set_instr(1, 1, 0, 0, 2, 1, 32'h5000);
        step(1);
        #2;
        rst_n = 0;
        #1;
        chk("async reset ex_valid", ex_valid, 0);
        chk("async reset ex_pc", ex_pc, 0);
        @(posedge clk); #1;
        set_idle();
        model_reset();
        rst_n = 1;

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            dec_valid   = $urandom_range(0, 3) != 0;
            dec_rs1     = 5'($urandom_range(0, 7));
            dec_rs2     = 5'($urandom_range(0, 7));
            dec_rs1_use = $urandom_range(0, 1) == 1;
            dec_rs2_use = $urandom_range(0, 1) == 1;
            dec_rd      = 5'($urandom_range(0, 7));
            dec_rd_we   = $urandom_range(0, 3) != 0;
            dec_op      = 8'($urandom);
            dec_imm     = $urandom;
            dec_pc      = $urandom;
            r0_data     = $urandom;
            r1_data     = $urandom;
            r_v         = $urandom_range(0, 1) == 1;
            wb_valid    = $urandom_range(0, 2) == 0;
            wb_ad       = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            flush       = $urandom_range(0, 15) == 0;
            ex_ready    = $urandom_range(0, 9) < 7;
            step(1);
        end

        // saturation after a very long stall, with an x0 write check
        do_reset();
        set_instr(0, 0, 0, 0, 0, 1, 32'h6000);
        #1;
        chk("x0 write block_rd", block_rd, 0);
        step(1);
        if (BYP) begin
            set_instr(0, 0, 0, 0, 1, 1, 32'h6004);
            step(1);
        end
        set_instr(1, 1, 0, 0, 2, 1, 32'h6008);
        r_v = 0;
        for (int c = 0; c < 70000; c++) step(0);
        chk("stall saturated", stall_cycles, 16'hFFFF);
        step(1);
        chk("stall no wrap", stall_cycles, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand data width.
REQ-002 SHALL have parameter OPW, default 8, micro-op code width.
REQ-003 SHALL have ports clk in 1 (clock) and rst_n in 1 (asynchronous, active-low reset), listed first.
REQ-004 SHALL have decode-side inputs: dec_valid 1, dec_rs1/dec_rs2 5, dec_rs1_use/dec_rs2_use 1, dec_rd 5, dec_rd_we 1, dec_op OPW, dec_imm XLEN, dec_pc XLEN.
REQ-005 SHALL have decode-side output: dec_ready 1 (instruction accepted this cycle when dec_valid & dec_ready).
REQ-006 SHALL have register-file outputs r0_valid 1, r0_ad 5, r1_valid 1, r1_ad 5, block_rd 1, rd 5.
REQ-007 SHALL have register-file inputs: r0_data XLEN, r1_data XLEN, r_v 1 (1 = no pending source).
REQ-008 SHALL have writeback snoop inputs: wb_valid 1, wb_ad 5, wb_data XLEN; and flush in 1.
REQ-009 SHALL have execute-side outputs ex_valid 1, ex_rs1_data/ex_rs2_data XLEN, ex_op OPW, ex_imm XLEN, ex_pc XLEN, ex_rd 5, ex_rd_we 1, stall_cycles 16; input ex_ready 1.

Function
REQ-010 SHALL drive r0_valid=dec_valid&dec_rs1_use, r0_ad=dec_rs1, r1_valid=dec_valid&dec_rs2_use, r1_ad=dec_rs2, combinationally.
REQ-011 SHALL define hazard=dec_valid&!r_v (see REQ-021 under BYPASS_EN).
REQ-012 SHALL assert dec_ready=!hazard&!flush&(!ex_valid|ex_ready).
REQ-013 SHALL, on accept, register operands/op/imm/pc/rd/rd_we into ex_* at next edge with ex_valid=1 (1-cycle latency); unused source data SHALL be 0.
REQ-014 SHALL, on accept with dec_rd_we=1 and dec_rd!=0, pulse block_rd=1 with rd=dec_rd the same cycle; otherwise block_rd=0, rd=0.
REQ-015 SHALL hold all ex_* stable while ex_valid&!ex_ready; SHALL clear ex_valid when ex_ready and no new accept.
REQ-016 SHALL implement FSM IDLE (ex_valid=0), BUSY (ex_valid=1), HAZARD (dec_valid&hazard); transitions: any->HAZARD on hazard, HAZARD->BUSY on accept, BUSY->IDLE on ex_ready&!accept, any->IDLE on flush.
REQ-017 SHALL on flush clear ex_valid at next edge, accept nothing, assert no block_rd that cycle; pending scoreboard marks are not undone.
REQ-018 SHALL increment stall_cycles each cycle in HAZARD, saturating at 16'hFFFF, never wrapping.
REQ-019 SHALL treat x0 sources as never hazardous and read-data 0.

Reset
REQ-020 SHALL on rst_n=0 asynchronously set FSM=IDLE, ex_valid=0, all ex_* =0, stall_cycles=0, shadow mask=0; mid-operation reset discards the held instruction.

Configuration
REQ-021 SHALL with BYPASS_EN defined keep a 32-bit shadow pending mask (set on block_rd, cleared on wb_valid at wb_ad), compute hazard per source from it, and for a source with wb_valid&wb_ad==source&source!=0 treat it clear and forward wb_data same cycle.
REQ-022 SHALL without BYPASS_EN have no shadow mask, ignore wb_data, and stall until r_v=1.

Structure
REQ-023 SHALL take XLEN, register-address width and the FSM state typedef from the shared cpu_configuration package.
REQ-024 SHALL place the BYPASS_EN shadow mask and forward mux in sub-module issue_bypass.

Verification
REQ-025 Independent add x3=x1+x2, r_v=1, ex_ready=1 -> ex_valid next cycle, block_rd=1,rd=3 in accept cycle.
REQ-026 RAW on x3 with r_v=0 for 4 cycles -> dec_ready=0, FSM HAZARD, stall_cycles=4, issue on cycle r_v=1.
REQ-027 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, dec_ready=0, no block_rd.
REQ-028 Flush while BUSY and dec_valid=1 -> ex_valid=0 next cycle, block_rd=0, FSM IDLE.
REQ-029 BYPASS_EN: x5 pending, wb_valid=1 wb_ad=5 wb_data=32'hDEADBEEF same cycle -> issue same cycle, ex_rs1_data=32'hDEADBEEF.
REQ-030 Write to x0 (dec_rd=0, dec_rd_we=1) -> block_rd=0; 70000 hazard cycles -> stall_cycles=16'hFFFF.
